// File: rtl/inv_shift_rows_stage.sv
// Elastic registered AES InvShiftRows stage with a 2-entry skid buffer and a sideband tag.
// Optional integrity checker built when INV_SHIFT_CHECK_EN is defined.
module inv_shift_rows_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic             fault
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // out(r,c) = in(r,(c-r) mod 4); byte(r,c) lives at bits [127-8*(4c+r) -: 8]
  function automatic logic [127:0] inv_map(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [127:0]     out_state_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [127:0]     skid_state_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             ld_out_in;
  logic             ld_out_skid;
  logic             ld_skid;

  // in_ready/out_valid are fixed per state, so accept/drain reduce to in_valid/out_ready
  always_comb begin
    state_d     = state_q;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            ld_out_in = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_valid && !out_ready) begin
            ld_skid = 1'b1;
            state_d = FULL;
          end else if (in_valid && out_ready) begin
            ld_out_in = 1'b1;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            ld_out_skid = 1'b1;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_state_q  <= '0;
      out_tag_q    <= '0;
      skid_state_q <= '0;
      skid_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (ld_out_in) begin
        out_state_q <= inv_map(in_state);
        out_tag_q   <= in_tag;
      end else if (ld_out_skid) begin
        out_state_q <= skid_state_q;
        out_tag_q   <= skid_tag_q;
      end
      if (ld_skid) begin
        skid_state_q <= inv_map(in_state);
        skid_tag_q   <= in_tag;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_tag   = out_tag_q;
  assign occupancy = state_q;

`ifdef INV_SHIFT_CHECK_EN
  // out'(r,c) = out(r,(c+r) mod 4) undoes the inverse mapping
  function automatic logic [127:0] fwd_map(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  logic [127:0] orig_out_q;
  logic [127:0] orig_skid_q;
  logic         fault_q;

  // Raw input copies follow the same load paths as the mapped data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_out_q  <= '0;
      orig_skid_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (ld_out_in) begin
        orig_out_q <= in_state;
      end else if (ld_out_skid) begin
        orig_out_q <= orig_skid_q;
      end
      if (ld_skid) begin
        orig_skid_q <= in_state;
      end
      if (fwd_map(out_state_q) != orig_out_q) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: doc/inv_shift_rows_stage.md
Name: inv_shift_rows_stage

Overview:
Elastic, registered pipeline stage that applies AES InvShiftRows to a 128-bit state. It is the decrypt-direction counterpart of the encrypt-path ShiftRows mapping.
- Sits in the inverse-cipher round datapath, between round-key addition and InvSubBytes.
- Uses a valid/ready handshake on both sides, with a 2-entry skid buffer for full throughput.
- Carries a sideband tag alongside each state.

Parameters:
TAG_W, 4, width of the sideband tag (round index / context id) carried with each state; legal range 1..16.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream state valid
in_ready  out  1  stage can accept a state this cycle
in_state  in  128  input state; byte(r,c) at bits [127-8*(4c+r) -: 8], column 0 in MSB word
in_tag  in  TAG_W  sideband tag for in_state
out_valid  out  1  output state valid
out_ready  in  1  downstream accepts
out_state  out  128  InvShiftRows(in_state), same byte layout
out_tag  out  TAG_W  tag accompanying out_state
flush  in  1  synchronous clear of all buffered entries
occupancy  out  2  number of held entries (0..2)
fault  out  1  sticky integrity fault (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low (rst_n). Reset values:
  - out_valid=0, in_ready=1, occupancy=0, fault=0.
  - out_state=0, out_tag=0, skid register=0.
- Mapping: out(r,c) = in(r,(c-r) mod 4).
  - Row 0 is unchanged.
  - Row 1 rotates right by 1 column, row 2 by 2, row 3 by 3.
  - The transform is purely combinational on the input side; the result is registered.
- Transfer rule: a transfer occurs when valid&&ready on that side. Source holds valid/data stable until accepted. out_valid never drops without a transfer or flush.
- Latency: a state accepted at cycle N appears on out_state at N+1. Back-to-back throughput is 1 state/cycle while out_ready=1.
- States (by occupancy):
  - EMPTY(0): in_ready=1, out_valid=0.
    - Accept → ONE.
  - ONE(1): in_ready=1, out_valid=1.
    - accept && !drain → FULL.
    - drain && !accept → EMPTY.
    - both → stay ONE; output register loads the new state.
  - FULL(2): in_ready=0, out_valid=1. The second entry is held in the skid register.
    - Drain → ONE; skid moves into the output register.
    - No accept possible in FULL.
- in_ready is a registered signal: it depends only on occupancy, never combinationally on out_ready.
- Ordering: strict FIFO; tags always stay paired with their own state.
- flush: takes priority over all handshakes in its cycle.
  - Next cycle: occupancy=0, out_valid=0.
  - Any input offered in the flush cycle is dropped; in_ready reads 1 next cycle.
  - fault is not cleared by flush.
- Reset mid-operation discards all entries immediately (async), with no partial output.
- in_valid with in_ready=0 has no effect; the source must hold.

Optional Feature:
Macro INV_SHIFT_CHECK_EN.
- Defined:
  - Every state loaded into the output register is re-mapped through forward ShiftRows, out'(r,c)=out(r,(c+r) mod 4).
  - The result is compared against a registered copy of the original input (128 extra flops per entry).
  - On mismatch, fault sets on the next cycle and stays 1 until rst_n. Data flow is not altered.
  - This covers fault-injection detection on the datapath flops.
- Undefined: the checker and its copy registers are not built; fault is tied 0.

Test Plan:
1. Single transfer: in_state=128'h000102030405060708090a0b0c0d0e0f, in_tag=3, out_ready=1.
   → next cycle out_valid=1, out_state=128'h000d0a07_04010e0b_0805020f_0c090603, out_tag=3.
2. Back-to-back streaming: 8 random states with out_ready=1.
   → outputs in order, one per cycle, 1-cycle latency; in_ready stays 1; occupancy stays ≤1.
3. Backpressure: out_ready=0 while 3 states are offered.
   → first two accepted (occupancy 1 then 2); in_ready=0 from the cycle after the 2nd accept; 3rd held by source.
   Then release out_ready → all three emerge in order with correct tags.
4. Flush at occupancy=2 with in_valid=1 in the same cycle.
   → next cycle occupancy=0, out_valid=0, offered state dropped; a following transfer works normally.
5. Async reset mid-stream: assert rst_n=0 between clock edges at occupancy=2.
   → out_valid, occupancy, out_state clear immediately, without waiting for a clock edge; in_ready=1.
6. With INV_SHIFT_CHECK_EN: force one output-register bit flip.
   → fault=1 next cycle and stays 1 through a flush, clearing only on rst_n.
   Without the macro, fault stays 0 under the same stimulus.
